// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared reorder buffer constants and entry payload layout
//
// Purpose: default geometry of the reorder buffer and the bit layout of an
// entry payload, shared with rename (which packs dest/old/has_dest) and the
// execution units (which fill the data field).
// Payload layout, LSB first: data[DATA_W], old[ar_w], dest[ar_w], has_dest.
package rob_pkg;

  localparam int ROB_DEPTH_DEF = 16;
  localparam int PTR_W_DEF     = 4;
  localparam int AR_SIZE_DEF   = 6;
  localparam int DATA_W        = 32;

  localparam int DATA_LSB = 0;
  localparam int OLD_LSB  = DATA_LSB + DATA_W;

  function automatic int dest_lsb(input int ar_w);
    return OLD_LSB + ar_w;
  endfunction

  function automatic int has_dest_bit(input int ar_w);
    return OLD_LSB + 2 * ar_w;
  endfunction

  function automatic int payload_w(input int ar_w);
    return OLD_LSB + 2 * ar_w + 1;
  endfunction

endpackage

// File: rtl/rob_retire_select.sv
// rtl/rob_retire_select.sv - picks up to two oldest completed entries to retire
//
// Purpose: combinational retire decision for the two oldest slots.
// Ports:
//   a_valid/a_done/a_payload : entry at head
//   b_valid/b_done/b_payload : entry at head+1
//   retire_cnt               : entries leaving the buffer (0, 1 or 2)
//   wr_a/wr_b                : slot retires and writes the register file
//   dest_x/old_x/data_x      : unpacked slot payload fields
module rob_retire_select
  import rob_pkg::*;
#(
  parameter int AR_SIZE = AR_SIZE_DEF,
  localparam int PL_W   = payload_w(AR_SIZE)
) (
  input  logic               a_valid,
  input  logic               a_done,
  input  logic [PL_W-1:0]    a_payload,
  input  logic               b_valid,
  input  logic               b_done,
  input  logic [PL_W-1:0]    b_payload,
  output logic [1:0]         retire_cnt,
  output logic               wr_a,
  output logic               wr_b,
  output logic [AR_SIZE-1:0] dest_a,
  output logic [AR_SIZE-1:0] old_a,
  output logic [DATA_W-1:0]  data_a,
  output logic [AR_SIZE-1:0] dest_b,
  output logic [AR_SIZE-1:0] old_b,
  output logic [DATA_W-1:0]  data_b
);

  localparam int DEST_LSB = dest_lsb(AR_SIZE);
  localparam int HD_BIT   = has_dest_bit(AR_SIZE);

  logic go_a;
  logic go_b;

  // Retirement stays in order: slot B may only leave together with slot A.
  assign go_a = a_valid & a_done;
  assign go_b = go_a & b_valid & b_done;

  always_comb begin
    retire_cnt = 2'd0;
    if (go_b) begin
      retire_cnt = 2'd2;
    end else if (go_a) begin
      retire_cnt = 2'd1;
    end
  end

  assign wr_a   = go_a & a_payload[HD_BIT];
  assign wr_b   = go_b & b_payload[HD_BIT];
  assign dest_a = a_payload[DEST_LSB +: AR_SIZE];
  assign old_a  = a_payload[OLD_LSB +: AR_SIZE];
  assign data_a = a_payload[DATA_LSB +: DATA_W];
  assign dest_b = b_payload[DEST_LSB +: AR_SIZE];
  assign old_b  = b_payload[OLD_LSB +: AR_SIZE];
  assign data_b = b_payload[DATA_LSB +: DATA_W];

endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement buffer feeding the register file
//
// Purpose: circular buffer of in-flight instructions. Rename allocates one
// entry per cycle, two execution ports complete entries by tag, and up to
// two oldest completed entries retire per cycle onto the dual write port.
// Ports:
//   clk, rstn                     : clock, async active-low reset
//   alloc_valid/has_dest/dest/old : allocation request from rename
//   alloc_ready, alloc_tag        : not full, tag granted (tail index)
//   cmplN_valid/tag/data          : completion ports 0 and 1 (port 0 wins)
//   flush                         : discard all entries
//   write_back, retireN, write_addrN, write_dataN, old_addrN : retire outputs
//   count                         : occupied entries
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int ROB_DEPTH = ROB_DEPTH_DEF,
  parameter int PTR_W     = PTR_W_DEF,
  parameter int AR_SIZE   = AR_SIZE_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               alloc_valid,
  input  logic               alloc_has_dest,
  input  logic [AR_SIZE-1:0] alloc_dest,
  input  logic [AR_SIZE-1:0] alloc_old,
  output logic               alloc_ready,
  output logic [PTR_W-1:0]   alloc_tag,
  input  logic               cmpl0_valid,
  input  logic [PTR_W-1:0]   cmpl0_tag,
  input  logic [DATA_W-1:0]  cmpl0_data,
  input  logic               cmpl1_valid,
  input  logic [PTR_W-1:0]   cmpl1_tag,
  input  logic [DATA_W-1:0]  cmpl1_data,
  input  logic               flush,
  output logic               write_back,
  output logic               retire1,
  output logic               retire2,
  output logic [AR_SIZE-1:0] write_addr1,
  output logic [AR_SIZE-1:0] write_addr2,
  output logic [DATA_W-1:0]  write_data1,
  output logic [DATA_W-1:0]  write_data2,
  output logic [AR_SIZE-1:0] old_addr1,
  output logic [AR_SIZE-1:0] old_addr2,
  output logic [PTR_W:0]     count
);

  localparam int               PL_W    = payload_w(AR_SIZE);
  localparam logic [PTR_W:0]   PTR_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] IDX_ONE = PTR_W'(1);

  // One extra pointer bit distinguishes full from empty.
  logic [PTR_W:0]       head;
  logic [PTR_W:0]       tail;
  logic [ROB_DEPTH-1:0] valid;
  logic [ROB_DEPTH-1:0] done;
  logic [PL_W-1:0]      payload [ROB_DEPTH];

  logic [PTR_W-1:0] head_idx;
  logic [PTR_W-1:0] head1_idx;
  logic [PTR_W-1:0] tail_idx;
  logic             full;
  logic             alloc_fire;
  logic             cmpl0_hit;
  logic             cmpl1_hit;

  logic [1:0]         sel_cnt;
  logic               sel_wr_a;
  logic               sel_wr_b;
  logic [AR_SIZE-1:0] sel_dest_a;
  logic [AR_SIZE-1:0] sel_old_a;
  logic [DATA_W-1:0]  sel_data_a;
  logic [AR_SIZE-1:0] sel_dest_b;
  logic [AR_SIZE-1:0] sel_old_b;
  logic [DATA_W-1:0]  sel_data_b;

  assign head_idx  = head[PTR_W-1:0];
  assign head1_idx = head_idx + IDX_ONE;
  assign tail_idx  = tail[PTR_W-1:0];
  assign full      = (head_idx == tail_idx) && (head[PTR_W] != tail[PTR_W]);
  assign count     = tail - head;

  // Ready depends only on registered pointers; a same-cycle retirement does
  // not open a slot for a same-cycle allocation.
  assign alloc_ready = !full;
  assign alloc_tag   = tail_idx;
  assign alloc_fire  = alloc_valid && !full && !flush;

  // Completions check the pre-edge valid bit, so completing a tag in the
  // same cycle it is allocated is dropped.
  assign cmpl0_hit = cmpl0_valid && valid[cmpl0_tag] && !flush;
  assign cmpl1_hit = cmpl1_valid && valid[cmpl1_tag] && !flush;

  rob_retire_select #(
    .AR_SIZE (AR_SIZE)
  ) u_retire_select (
    .a_valid    (valid[head_idx]),
    .a_done     (done[head_idx]),
    .a_payload  (payload[head_idx]),
    .b_valid    (valid[head1_idx]),
    .b_done     (done[head1_idx]),
    .b_payload  (payload[head1_idx]),
    .retire_cnt (sel_cnt),
    .wr_a       (sel_wr_a),
    .wr_b       (sel_wr_b),
    .dest_a     (sel_dest_a),
    .old_a      (sel_old_a),
    .data_a     (sel_data_a),
    .dest_b     (sel_dest_b),
    .old_b      (sel_old_b),
    .data_b     (sel_data_b)
  );

  // Payload storage needs no reset: it is only observed for entries that
  // were allocated and completed.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      payload[tail_idx][PL_W-1:OLD_LSB] <= {alloc_has_dest, alloc_dest, alloc_old};
    end
    // Port 1 first so port 0 overrides when both hit the same tag.
    if (cmpl1_hit) begin
      payload[cmpl1_tag][DATA_LSB +: DATA_W] <= cmpl1_data;
    end
    if (cmpl0_hit) begin
      payload[cmpl0_tag][DATA_LSB +: DATA_W] <= cmpl0_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head        <= '0;
      tail        <= '0;
      valid       <= '0;
      done        <= '0;
      write_back  <= 1'b0;
      retire1     <= 1'b0;
      retire2     <= 1'b0;
      write_addr1 <= '0;
      write_addr2 <= '0;
      write_data1 <= '0;
      write_data2 <= '0;
      old_addr1   <= '0;
      old_addr2   <= '0;
    end else if (flush) begin
      head       <= '0;
      tail       <= '0;
      valid      <= '0;
      done       <= '0;
      write_back <= 1'b0;
      retire1    <= 1'b0;
      retire2    <= 1'b0;
    end else begin
      if (alloc_fire) begin
        valid[tail_idx] <= 1'b1;
        done[tail_idx]  <= 1'b0;
        tail            <= tail + PTR_ONE;
      end
      if (cmpl1_hit) begin
        done[cmpl1_tag] <= 1'b1;
      end
      if (cmpl0_hit) begin
        done[cmpl0_tag] <= 1'b1;
      end
      // Alloc never targets head/head+1 while those hold live entries, so
      // these clears cannot collide with the allocation write above.
      if (sel_cnt != 2'd0) begin
        valid[head_idx] <= 1'b0;
      end
      if (sel_cnt == 2'd2) begin
        valid[head1_idx] <= 1'b0;
      end
      head <= head + (PTR_W + 1)'(sel_cnt);

      retire1    <= sel_wr_a;
      retire2    <= sel_wr_b;
      write_back <= sel_wr_a | sel_wr_b;
      // Slot fields follow any retirement, including silent ones.
      if (sel_cnt != 2'd0) begin
        write_addr1 <= sel_dest_a;
        old_addr1   <= sel_old_a;
        write_data1 <= sel_data_a;
      end
      if (sel_cnt == 2'd2) begin
        write_addr2 <= sel_dest_b;
        old_addr2   <= sel_old_b;
        write_data2 <= sel_data_b;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed vector bench for reorder_buffer
module tb_reorder_buffer;

  typedef struct {
    logic        rs;
    logic        av;
    logic        hd;
    logic [5:0]  dst;
    logic [5:0]  old;
    logic        c0v;
    logic [3:0]  c0t;
    logic [31:0] c0d;
    logic        c1v;
    logic [3:0]  c1t;
    logic [31:0] c1d;
    logic        fl;
    logic [4:0]  e_cnt;
    logic        e_rdy;
    logic [3:0]  e_tag;
    logic        e_r1;
    logic        e_r2;
    logic        ck1;
    logic [5:0]  e_a1;
    logic [5:0]  e_o1;
    logic [31:0] e_d1;
    logic        ck2;
    logic [5:0]  e_a2;
    logic [5:0]  e_o2;
    logic [31:0] e_d2;
  } vec_t;

  vec_t vq[$];
  logic pend_rs = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  logic        clk = 1'b0;
  logic        rstn;
  logic        alloc_valid;
  logic        alloc_has_dest;
  logic [5:0]  alloc_dest;
  logic [5:0]  alloc_old;
  logic        alloc_ready;
  logic [3:0]  alloc_tag;
  logic        cmpl0_valid;
  logic [3:0]  cmpl0_tag;
  logic [31:0] cmpl0_data;
  logic        cmpl1_valid;
  logic [3:0]  cmpl1_tag;
  logic [31:0] cmpl1_data;
  logic        flush;
  logic        write_back;
  logic        retire1;
  logic        retire2;
  logic [5:0]  write_addr1;
  logic [5:0]  write_addr2;
  logic [31:0] write_data1;
  logic [31:0] write_data2;
  logic [5:0]  old_addr1;
  logic [5:0]  old_addr2;
  logic [4:0]  count;

  reorder_buffer #(
    .ROB_DEPTH (16),
    .PTR_W     (4),
    .AR_SIZE   (6)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .alloc_valid    (alloc_valid),
    .alloc_has_dest (alloc_has_dest),
    .alloc_dest     (alloc_dest),
    .alloc_old      (alloc_old),
    .alloc_ready    (alloc_ready),
    .alloc_tag      (alloc_tag),
    .cmpl0_valid    (cmpl0_valid),
    .cmpl0_tag      (cmpl0_tag),
    .cmpl0_data     (cmpl0_data),
    .cmpl1_valid    (cmpl1_valid),
    .cmpl1_tag      (cmpl1_tag),
    .cmpl1_data     (cmpl1_data),
    .flush          (flush),
    .write_back     (write_back),
    .retire1        (retire1),
    .retire2        (retire2),
    .write_addr1    (write_addr1),
    .write_addr2    (write_addr2),
    .write_data1    (write_data1),
    .write_data2    (write_data2),
    .old_addr1      (old_addr1),
    .old_addr2      (old_addr2),
    .count          (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic av, input logic hd, input logic [5:0] dst, input logic [5:0] old,
                     input logic c0v, input logic [3:0] c0t, input logic [31:0] c0d,
                     input logic c1v, input logic [3:0] c1t, input logic [31:0] c1d,
                     input logic fl, input logic [4:0] cnt, input logic rdy, input logic [3:0] tag,
                     input logic r1, input logic r2);
    vec_t v;
    v.rs = pend_rs;
    pend_rs = 1'b0;
    v.av = av;  v.hd = hd;  v.dst = dst;  v.old = old;
    v.c0v = c0v; v.c0t = c0t; v.c0d = c0d;
    v.c1v = c1v; v.c1t = c1t; v.c1d = c1d;
    v.fl = fl;
    v.e_cnt = cnt; v.e_rdy = rdy; v.e_tag = tag; v.e_r1 = r1; v.e_r2 = r2;
    v.ck1 = 1'b0; v.e_a1 = '0; v.e_o1 = '0; v.e_d1 = '0;
    v.ck2 = 1'b0; v.e_a2 = '0; v.e_o2 = '0; v.e_d2 = '0;
    vq.push_back(v);
  endtask

  task automatic al(input logic hd, input logic [5:0] dst, input logic [5:0] old,
                    input logic [4:0] cnt, input logic rdy, input logic [3:0] tag);
    add(1'b1, hd, dst, old, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, cnt, rdy, tag, 1'b0, 1'b0);
  endtask

  task automatic cp(input logic c0v, input logic [3:0] c0t, input logic [31:0] c0d,
                    input logic c1v, input logic [3:0] c1t, input logic [31:0] c1d,
                    input logic [4:0] cnt, input logic rdy, input logic [3:0] tag,
                    input logic r1, input logic r2);
    add(1'b0, 1'b0, 6'd0, 6'd0, c0v, c0t, c0d, c1v, c1t, c1d, 1'b0, cnt, rdy, tag, r1, r2);
  endtask

  task automatic idle(input logic [4:0] cnt, input logic rdy, input logic [3:0] tag,
                      input logic r1, input logic r2);
    cp(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, cnt, rdy, tag, r1, r2);
  endtask

  task automatic f1(input logic [5:0] a, input logic [5:0] o, input logic [31:0] d);
    vq[vq.size()-1].ck1  = 1'b1;
    vq[vq.size()-1].e_a1 = a;
    vq[vq.size()-1].e_o1 = o;
    vq[vq.size()-1].e_d1 = d;
  endtask

  task automatic f2(input logic [5:0] a, input logic [5:0] o, input logic [31:0] d);
    vq[vq.size()-1].ck2  = 1'b1;
    vq[vq.size()-1].e_a2 = a;
    vq[vq.size()-1].e_o2 = o;
    vq[vq.size()-1].e_d2 = d;
  endtask

  task automatic drive_idle();
    alloc_valid = 1'b0; alloc_has_dest = 1'b0; alloc_dest = '0; alloc_old = '0;
    cmpl0_valid = 1'b0; cmpl0_tag = '0; cmpl0_data = '0;
    cmpl1_valid = 1'b0; cmpl1_tag = '0; cmpl1_data = '0;
    flush = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vq[i];
    @(negedge clk);
    if (v.rs) begin
      rstn = 1'b0;
      #1;
      rstn = 1'b1;
    end
    alloc_valid = v.av; alloc_has_dest = v.hd; alloc_dest = v.dst; alloc_old = v.old;
    cmpl0_valid = v.c0v; cmpl0_tag = v.c0t; cmpl0_data = v.c0d;
    cmpl1_valid = v.c1v; cmpl1_tag = v.c1t; cmpl1_data = v.c1d;
    flush = v.fl;
    @(posedge clk);
    #1;
    chk("count", i, 32'(count), 32'(v.e_cnt));
    chk("alloc_ready", i, 32'(alloc_ready), 32'(v.e_rdy));
    chk("alloc_tag", i, 32'(alloc_tag), 32'(v.e_tag));
    chk("retire1", i, 32'(retire1), 32'(v.e_r1));
    chk("retire2", i, 32'(retire2), 32'(v.e_r2));
    chk("write_back", i, 32'(write_back), 32'(v.e_r1 | v.e_r2));
    if (v.ck1) begin
      chk("write_addr1", i, 32'(write_addr1), 32'(v.e_a1));
      chk("old_addr1", i, 32'(old_addr1), 32'(v.e_o1));
      chk("write_data1", i, write_data1, v.e_d1);
    end
    if (v.ck2) begin
      chk("write_addr2", i, 32'(write_addr2), 32'(v.e_a2));
      chk("old_addr2", i, 32'(old_addr2), 32'(v.e_o2));
      chk("write_data2", i, write_data2, v.e_d2);
    end
  endtask

  task automatic check_all_zero(input int idx);
    chk("rst count", idx, 32'(count), 32'd0);
    chk("rst alloc_ready", idx, 32'(alloc_ready), 32'd1);
    chk("rst alloc_tag", idx, 32'(alloc_tag), 32'd0);
    chk("rst write_back", idx, 32'(write_back), 32'd0);
    chk("rst retire1", idx, 32'(retire1), 32'd0);
    chk("rst retire2", idx, 32'(retire2), 32'd0);
    chk("rst write_addr1", idx, 32'(write_addr1), 32'd0);
    chk("rst write_addr2", idx, 32'(write_addr2), 32'd0);
    chk("rst old_addr1", idx, 32'(old_addr1), 32'd0);
    chk("rst old_addr2", idx, 32'(old_addr2), 32'd0);
    chk("rst write_data1", idx, write_data1, 32'd0);
    chk("rst write_data2", idx, write_data2, 32'd0);
  endtask

  initial begin
    // Single retire.
    pend_rs = 1'b1;
    al(1'b1, 6'd33, 6'd5, 5'd1, 1'b1, 4'd1);
    cp(1'b1, 4'd0, 32'h1234, 1'b0, 4'd0, 32'd0, 5'd1, 1'b1, 4'd1, 1'b0, 1'b0);
    idle(5'd0, 1'b1, 4'd1, 1'b1, 1'b0); f1(6'd33, 6'd5, 32'h1234);
    idle(5'd0, 1'b1, 4'd1, 1'b0, 1'b0);

    // Out-of-order completion, dual retire.
    pend_rs = 1'b1;
    al(1'b1, 6'd10, 6'd20, 5'd1, 1'b1, 4'd1);
    al(1'b1, 6'd11, 6'd21, 5'd2, 1'b1, 4'd2);
    al(1'b1, 6'd12, 6'd22, 5'd3, 1'b1, 4'd3);
    cp(1'b1, 4'd2, 32'hA2, 1'b0, 4'd0, 32'd0, 5'd3, 1'b1, 4'd3, 1'b0, 1'b0);
    cp(1'b1, 4'd1, 32'hA1, 1'b0, 4'd0, 32'd0, 5'd3, 1'b1, 4'd3, 1'b0, 1'b0);
    cp(1'b1, 4'd0, 32'hA0, 1'b0, 4'd0, 32'd0, 5'd3, 1'b1, 4'd3, 1'b0, 1'b0);
    idle(5'd1, 1'b1, 4'd3, 1'b1, 1'b1); f1(6'd10, 6'd20, 32'hA0); f2(6'd11, 6'd21, 32'hA1);
    idle(5'd0, 1'b1, 4'd3, 1'b1, 1'b0); f1(6'd12, 6'd22, 32'hA2);
    idle(5'd0, 1'b1, 4'd3, 1'b0, 1'b0);

    // No-destination entry retires silently next to a writing one.
    pend_rs = 1'b1;
    al(1'b0, 6'd7, 6'd8, 5'd1, 1'b1, 4'd1);
    al(1'b1, 6'd40, 6'd41, 5'd2, 1'b1, 4'd2);
    cp(1'b1, 4'd0, 32'h50, 1'b1, 4'd1, 32'h51, 5'd2, 1'b1, 4'd2, 1'b0, 1'b0);
    idle(5'd0, 1'b1, 4'd2, 1'b0, 1'b1); f1(6'd7, 6'd8, 32'h50); f2(6'd40, 6'd41, 32'h51);

    // Completion in the allocation cycle is dropped; port 0 wins a tie.
    pend_rs = 1'b1;
    add(1'b1, 1'b1, 6'd1, 6'd2, 1'b1, 4'd0, 32'h77, 1'b0, 4'd0, 32'd0, 1'b0, 5'd1, 1'b1, 4'd1, 1'b0, 1'b0);
    idle(5'd1, 1'b1, 4'd1, 1'b0, 1'b0);
    idle(5'd1, 1'b1, 4'd1, 1'b0, 1'b0);
    cp(1'b1, 4'd0, 32'h78, 1'b1, 4'd0, 32'h99, 5'd1, 1'b1, 4'd1, 1'b0, 1'b0);
    idle(5'd0, 1'b1, 4'd1, 1'b1, 1'b0); f1(6'd1, 6'd2, 32'h78);

    // Fill, overflow attempt, tag reuse, and retirement across 15 -> 0.
    pend_rs = 1'b1;
    for (int i = 0; i < 16; i++) begin
      al(1'b1, 6'(i), 6'(i + 32), 5'(i + 1), (i + 1) < 16, 4'(i + 1));
    end
    al(1'b1, 6'd50, 6'd50, 5'd16, 1'b0, 4'd0);
    cp(1'b1, 4'd0, 32'h100, 1'b1, 4'd1, 32'h101, 5'd16, 1'b0, 4'd0, 1'b0, 1'b0);
    idle(5'd14, 1'b1, 4'd0, 1'b1, 1'b1); f1(6'd0, 6'd32, 32'h100); f2(6'd1, 6'd33, 32'h101);
    al(1'b1, 6'd16, 6'd48, 5'd15, 1'b1, 4'd1);
    al(1'b1, 6'd17, 6'd49, 5'd16, 1'b0, 4'd2);
    for (int j = 0; j < 6; j++) begin
      cp(1'b1, 4'(2 + 2 * j), 32'(258 + 2 * j), 1'b1, 4'(3 + 2 * j), 32'(259 + 2 * j),
         5'(16 - 2 * j), j != 0, 4'd2, j != 0, j != 0);
      if (j != 0) begin
        f1(6'(2 * j), 6'(2 * j + 32), 32'(256 + 2 * j));
        f2(6'(2 * j + 1), 6'(2 * j + 33), 32'(257 + 2 * j));
      end
    end
    cp(1'b1, 4'd14, 32'h10E, 1'b0, 4'd0, 32'd0, 5'd4, 1'b1, 4'd2, 1'b1, 1'b1);
    f1(6'd12, 6'd44, 32'h10C); f2(6'd13, 6'd45, 32'h10D);
    idle(5'd3, 1'b1, 4'd2, 1'b1, 1'b0); f1(6'd14, 6'd46, 32'h10E);
    cp(1'b1, 4'd15, 32'h10F, 1'b1, 4'd0, 32'h200, 5'd3, 1'b1, 4'd2, 1'b0, 1'b0);
    idle(5'd1, 1'b1, 4'd2, 1'b1, 1'b1); f1(6'd15, 6'd47, 32'h10F); f2(6'd16, 6'd48, 32'h200);
    cp(1'b1, 4'd1, 32'h201, 1'b0, 4'd0, 32'd0, 5'd1, 1'b1, 4'd2, 1'b0, 1'b0);
    idle(5'd0, 1'b1, 4'd2, 1'b1, 1'b0); f1(6'd17, 6'd49, 32'h201);

    // Flush with a ready head entry, plus same-cycle alloc and completion.
    pend_rs = 1'b1;
    for (int i = 0; i < 6; i++) begin
      al(1'b1, 6'(i + 1), 6'(i + 1), 5'(i + 1), 1'b1, 4'(i + 1));
    end
    cp(1'b1, 4'd0, 32'h55, 1'b0, 4'd0, 32'd0, 5'd6, 1'b1, 4'd6, 1'b0, 1'b0);
    add(1'b1, 1'b1, 6'd60, 6'd60, 1'b1, 4'd2, 32'h66, 1'b0, 4'd0, 32'd0, 1'b1, 5'd0, 1'b1, 4'd0, 1'b0, 1'b0);
    idle(5'd0, 1'b1, 4'd0, 1'b0, 1'b0);
    al(1'b1, 6'd9, 6'd9, 5'd1, 1'b1, 4'd1);
    cp(1'b1, 4'd0, 32'h9, 1'b0, 4'd0, 32'd0, 5'd1, 1'b1, 4'd1, 1'b0, 1'b0);
    idle(5'd0, 1'b1, 4'd1, 1'b1, 1'b0); f1(6'd9, 6'd9, 32'h9);

    // Power-on reset.
    drive_idle();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero(-1);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      run_vec(i);
    end

    // Asynchronous reset with five live entries and a retirement on the outputs.
    @(negedge clk);
    drive_idle();
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      alloc_valid = 1'b1; alloc_has_dest = 1'b1;
      alloc_dest = 6'(20 + i); alloc_old = 6'(i);
      @(negedge clk);
    end
    drive_idle();
    cmpl0_valid = 1'b1; cmpl0_tag = 4'd0; cmpl0_data = 32'hC0;
    cmpl1_valid = 1'b1; cmpl1_tag = 4'd1; cmpl1_data = 32'hC1;
    @(negedge clk);
    drive_idle();
    @(posedge clk);
    #1;
    chk("pre-rst retire1", 1000, 32'(retire1), 32'd1);
    chk("pre-rst retire2", 1000, 32'(retire2), 32'd1);
    chk("pre-rst count", 1000, 32'(count), 32'd3);
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero(1001);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("post-rst count", 1002, 32'(count), 32'd0);
    chk("post-rst retire1", 1002, 32'(retire1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement buffer for the out-of-order core, sitting directly upstream of the architectural register file write port. Rename allocates one entry per cycle in program order. Up to two execution units report completion by tag. Each cycle the block retires up to two oldest completed entries and drives the register file's dual write-back port (`write_back`, `retireN`, `write_addrN`, `write_dataN`, `old_addrN`).

## Interface
Parameters:
- `ROB_DEPTH`, 16: number of entries; power of two.
- `PTR_W`, 4: log2(`ROB_DEPTH`); tag width.
- `AR_SIZE`, 6: register index width, matching the register file.

Ports (clock and reset fixed: one clock; reset is asynchronous and active-low):
- `clk` in 1: clock; all state updates on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `alloc_valid` in 1: allocate one entry this cycle.
- `alloc_has_dest` in 1: instruction writes a register.
- `alloc_dest` in `AR_SIZE`: renamed destination index.
- `alloc_old` in `AR_SIZE`: original (pre-rename) destination index.
- `alloc_ready` out 1: buffer not full.
- `alloc_tag` out `PTR_W`: tag granted to an allocation this cycle; equals tail index.
- `cmpl0_valid` / `cmpl1_valid` in 1: completion strobes.
- `cmpl0_tag` / `cmpl1_tag` in `PTR_W`: completing entry.
- `cmpl0_data` / `cmpl1_data` in 32: result value.
- `flush` in 1: discard all entries.
- `write_back` out 1: `retire1 | retire2`.
- `retire1` / `retire2` out 1: slot writes the register file.
- `write_addr1` / `write_addr2` out `AR_SIZE`: renamed destination index.
- `write_data1` / `write_data2` out 32: result value.
- `old_addr1` / `old_addr2` out `AR_SIZE`: original destination index.
- `count` out `PTR_W+1`: occupied entries.

## Operation
- Storage is a circular buffer. Each entry holds `valid`, `done`, `has_dest`, `dest`, `old`, and `data`.
- `head` and `tail` are `PTR_W+1` bits, and entries are indexed by the low `PTR_W` bits.
- Empty when `head == tail`. Full when the low bits are equal and the MSBs differ.
- `count = tail - head`, mod 2^(`PTR_W+1`).
- **Allocate:** if `alloc_valid && alloc_ready`, write the entry at `tail` with `valid=1`, `done=0`, and the input fields; `tail` increments.
  - `alloc_valid` while full is ignored. No state change.
  - `alloc_ready = !full`, computed from registered state only. A retirement in the same cycle does not free space for an allocation in that cycle.
- **Complete:** for each port, if `valid` and the entry at `tag` has `valid=1`, set `done=1` and store `data`.
  - Completion to an invalid entry is ignored.
  - If both ports hit the same tag, port 0 wins.
- **Retire selection** uses state before the edge.
  - Slot A = entry at `head`. It retires if `valid && done`.
  - Slot B = entry at `head+1`. It retires only if A retires and B is `valid && done`.
  - `head` advances by 0, 1 or 2, and retired entries are cleared to `valid=0`.
- **Outputs, registered at the same edge as the retirement:**
  - `retire1 = A retires && A.has_dest`.
  - `retire2 = B retires && B.has_dest`.
  - Addr/data/old fields are loaded from the slot even when its `retireN` is 0.
  - Entries without a destination retire silently. `retire2=1` with `retire1=0` is legal.
- **Flush** takes priority over everything in that cycle:
  - all `valid` cleared, `head = tail = 0`;
  - retire outputs 0 at that edge; alloc and completion in that cycle are dropped.

## Timing
- **Reset:** `head = tail = 0`; all `valid`/`done` = 0.
  - `write_back`, `retire1`, `retire2` = 0; all addr/data outputs = 0.
  - `alloc_ready = 1`, `alloc_tag = 0`, `count = 0`.
- **Latencies:**
  - Alloc at edge E0: the entry is completable from the cycle after E0. Completing the tag at edge E0 itself is ignored (entry not yet valid).
  - Completion at edge E1 → retire outputs asserted after E1+1 if the entry is at head. The register file commits at E1+2.
  - Retire outputs are held for exactly one cycle per retirement. They drop to 0 on any cycle with no retirement.
- **Wrap-around:** pointers wrap mod 2^(`PTR_W+1`). Slot B at index `ROB_DEPTH-1 → 0` must retire correctly.
- **Reset mid-operation:** immediate clear, including outputs; no retirement in flight survives.

## Structure
- Shared package `rob_pkg`:
  - entry field widths;
  - `ROB_DEPTH` / `PTR_W` defaults;
  - the entry bit-layout constants used by rename and the execution units.
- One natural sub-module, `rob_retire_select`: a combinational helper that takes head/head+1 entry fields and returns the retire count plus the two slot payloads. The pointer and entry state stays in `reorder_buffer`.

## Test plan
- **Reset:** assert `rstn=0` mid-run with 5 entries live → all outputs 0, `count=0`, `alloc_ready=1`.
- **Single retire:** alloc (`dest=p33`, `old=p5`); complete tag 0 with `data=0x1234` → one cycle later `retire1=1`, `write_addr1=33`, `old_addr1=5`, `write_data1=0x1234`, `retire2=0`, `count=0`.
- **Out-of-order completion and dual retire:** alloc tags 0, 1, 2; complete 2, then 1, then 0 → no retirement until tag 0 is done. Then tags 0 and 1 retire together (`retire1=retire2=1`), and tag 2 retires the next cycle.
- **No-destination entry:** alloc tag 0 without dest and tag 1 with dest; complete both → same cycle `retire1=0`, `retire2=1`, `write_back=1`.
- **Full/wrap:** fill 16 entries → `alloc_ready=0`, and a 17th alloc is ignored. Retire two, allocate two → tags 0 and 1 are reused, and retirement across index 15→0 is correct.
- **Flush:** 6 live entries, completion and alloc in the same cycle as `flush` → next cycle `count=0`, no retire outputs, and the next alloc gets `alloc_tag=0`.
